// File: rtl/dca_matrix_mac_lsu_scheduler.sv
// dca_matrix_mac_lsu_scheduler: sequences one macro instruction across A/B load LSUs, MAC datapath and C store LSU
module dca_matrix_mac_lsu_scheduler #(
   parameter int BW_LSU_INST = 32,
   parameter int BW_OP_COUNT = 16,
   localparam int BW_INST = 2 + 3 * BW_LSU_INST
) (
   input  logic                     clk,
   input  logic                     rstnn,
   input  logic                     clear_request,
   output logic                     clear_finish,
   input  logic                     inst_fifo_rready,
   input  logic [BW_INST-1:0]       inst_fifo_rdata,
   output logic                     inst_fifo_rrequest,
   output logic                     operation_finish,
   output logic                     ma_inst_wvalid,
   output logic [BW_LSU_INST-1:0]   ma_inst_wdata,
   input  logic                     ma_inst_wready,
   input  logic                     ma_inst_execute_finish,
   input  logic                     ma_busy,
   output logic                     mb_inst_wvalid,
   output logic [BW_LSU_INST-1:0]   mb_inst_wdata,
   input  logic                     mb_inst_wready,
   input  logic                     mb_inst_execute_finish,
   input  logic                     mb_busy,
   output logic                     mc_inst_wvalid,
   output logic [BW_LSU_INST-1:0]   mc_inst_wdata,
   input  logic                     mc_inst_wready,
   input  logic                     mc_inst_execute_finish,
   input  logic                     mc_busy,
   output logic                     compute_start,
   input  logic                     compute_done,
   output logic [BW_OP_COUNT+3:0]   status
);
   typedef enum logic [2:0] {IDLE, ISSUE_AB, WAIT_LOAD, COMPUTE, ISSUE_C, WAIT_STORE, FINISH, CLEAR} state_t;
   state_t                 state;
   logic [BW_INST-1:0]     inst;
   logic [BW_OP_COUNT-1:0] op_count;
   logic [2:0]             wvalid, issued, done, hs, fin;
   logic [1:0]             opcode, rd_op;
   logic                   pop, no_pending;
   // bit 0 = A load, bit 1 = B load, bit 2 = C store
   assign hs = wvalid & {mc_inst_wready, mb_inst_wready, ma_inst_wready};
   assign fin = {mc_inst_execute_finish, mb_inst_execute_finish, ma_inst_execute_finish};
   assign no_pending = ~|(wvalid & ~hs);
   assign opcode = inst[BW_INST-1 -: 2];
   assign rd_op = inst_fifo_rdata[BW_INST-1 -: 2];
   assign pop = (state == IDLE) & inst_fifo_rready & ~clear_request;
   assign inst_fifo_rrequest = rstnn & pop;
   assign {mc_inst_wvalid, mb_inst_wvalid, ma_inst_wvalid} = wvalid;
   assign ma_inst_wdata = inst[BW_LSU_INST-1:0];
   assign mb_inst_wdata = inst[2*BW_LSU_INST-1 -: BW_LSU_INST];
   assign mc_inst_wdata = inst[3*BW_LSU_INST-1 -: BW_LSU_INST];
   assign status = {op_count, state != IDLE, state};
   // control FSM: handshakes and finish tracking run in every state, transitions and pulses per state
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         state <= IDLE;
         inst <= '0;
         op_count <= '0;
         wvalid <= '0;
         issued <= '0;
         done <= '0;
         compute_start <= 1'b0;
         operation_finish <= 1'b0;
         clear_finish <= 1'b0;
      end else begin
         compute_start <= 1'b0;
         operation_finish <= 1'b0;
         clear_finish <= 1'b0;
         wvalid <= wvalid & ~hs;
         issued <= issued | hs;
         done <= done | (fin & (issued | hs));
         case (state)
            IDLE: begin
               if (clear_request) state <= CLEAR;
               else if (inst_fifo_rready) begin
                  inst <= inst_fifo_rdata;
                  state <= rd_op == 2'd3 ? FINISH : rd_op == 2'd2 ? ISSUE_C : ISSUE_AB;
                  wvalid <= rd_op == 2'd3 ? 3'b000 : rd_op == 2'd2 ? 3'b100 : 3'b011;
                  operation_finish <= rd_op == 2'd3;
               end
            end
            FINISH: begin
               op_count <= op_count + 1'b1;
               issued <= '0;
               done <= '0;
               state <= IDLE;
            end
            CLEAR: begin
               if (!ma_busy && !mb_busy && !mc_busy && !(|wvalid)) begin
                  clear_finish <= 1'b1;
                  issued <= '0;
                  done <= '0;
                  state <= IDLE;
               end
            end
            default: begin
               if (clear_request) begin
                  if (no_pending) state <= CLEAR;
               end else begin
                  case (state)
                     ISSUE_AB: if (&(issued[1:0] | hs[1:0])) state <= WAIT_LOAD;
                     WAIT_LOAD: begin
                        if (&done[1:0]) begin
                           state <= opcode == 2'd0 ? COMPUTE : FINISH;
                           compute_start <= opcode == 2'd0;
                           operation_finish <= opcode != 2'd0;
                        end
                     end
                     COMPUTE: begin
                        if (compute_done) begin
                           state <= ISSUE_C;
                           wvalid <= 3'b100;
                        end
                     end
                     ISSUE_C: if (hs[2]) state <= WAIT_STORE;
                     WAIT_STORE: begin
                        if (done[2]) begin
                           state <= FINISH;
                           operation_finish <= 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end
endmodule
